// File: rtl/exe_stage_fwd_if.sv
// exe_stage_fwd_if: bundles the ID/EX inputs, forwarding inputs and EX/MEM outputs
// of the execute stage. Signal prefixes are from the execute stage's point of view.
// The slave modport is taken by the execute stage, the master modport by its driver.
interface exe_stage_fwd_if #(
   parameter int DATA_W  = 32,
   parameter int REG_AW  = 5,
   parameter int SHAMT_W = 5
);
   // pipeline control
   logic               i_freeze;
   logic               i_flush;
   // ID/EX register contents
   logic [DATA_W-1:0]  i_operand_a;
   logic [DATA_W-1:0]  i_operand_b;
   logic [DATA_W-1:0]  i_imm_ext;
   logic [SHAMT_W-1:0] i_shamt;
   logic [5:0]         i_alu_control;
   logic               i_alu_src;
   logic [REG_AW-1:0]  i_read_reg_a;
   logic [REG_AW-1:0]  i_read_reg_b;
   logic [REG_AW-1:0]  i_write_reg;
   logic               i_do_writeback_id;
   logic               i_mem_read;
   logic               i_mem_write;
   logic               i_mem_to_reg;
   logic [31:0]        i_instr;
   // forwarding sources
   logic [DATA_W-1:0]  i_data_mem;
   logic [DATA_W-1:0]  i_data_wb;
   logic [REG_AW-1:0]  i_write_reg_mem;
   logic [REG_AW-1:0]  i_write_reg_wb;
   logic               i_do_writeback_mem;
   logic               i_do_writeback_wb;
   // results
   logic [DATA_W-1:0]  o_alu_result;
   logic [DATA_W-1:0]  o_alu_result_pr;
   logic [DATA_W-1:0]  o_read_data_b_pr;
   logic [REG_AW-1:0]  o_write_reg_pr;
   logic               o_do_writeback_pr;
   logic               o_mem_read_pr;
   logic               o_mem_write_pr;
   logic               o_mem_to_reg_pr;
   logic [5:0]         o_alu_control_pr;
   logic [31:0]        o_instr_pr;
   logic               o_stall;
   logic               o_mult_busy;

   modport slave (
      input  i_freeze, i_flush, i_operand_a, i_operand_b, i_imm_ext, i_shamt,
             i_alu_control, i_alu_src, i_read_reg_a, i_read_reg_b, i_write_reg,
             i_do_writeback_id, i_mem_read, i_mem_write, i_mem_to_reg, i_instr,
             i_data_mem, i_data_wb, i_write_reg_mem, i_write_reg_wb,
             i_do_writeback_mem, i_do_writeback_wb,
      output o_alu_result, o_alu_result_pr, o_read_data_b_pr, o_write_reg_pr,
             o_do_writeback_pr, o_mem_read_pr, o_mem_write_pr, o_mem_to_reg_pr,
             o_alu_control_pr, o_instr_pr, o_stall, o_mult_busy
   );

   modport master (
      output i_freeze, i_flush, i_operand_a, i_operand_b, i_imm_ext, i_shamt,
             i_alu_control, i_alu_src, i_read_reg_a, i_read_reg_b, i_write_reg,
             i_do_writeback_id, i_mem_read, i_mem_write, i_mem_to_reg, i_instr,
             i_data_mem, i_data_wb, i_write_reg_mem, i_write_reg_wb,
             i_do_writeback_mem, i_do_writeback_wb,
      input  o_alu_result, o_alu_result_pr, o_read_data_b_pr, o_write_reg_pr,
             o_do_writeback_pr, o_mem_read_pr, o_mem_write_pr, o_mem_to_reg_pr,
             o_alu_control_pr, o_instr_pr, o_stall, o_mult_busy
   );
endinterface

// File: rtl/exe_stage_fwd.sv
// exe_stage_fwd: execute stage with MEM/WB operand forwarding, ALU and EX/MEM register.
// Optional feature macro EXE_MULT_EN: shift-add unsigned multiplier (MULTU) writing
// HI/LO, read back with MFHI/MFLO, plus an interlock that stalls HI/LO users while busy.
// Without the macro, codes 12/14/15 produce 0 and stall/busy are tied low.
module exe_stage_fwd #(
   parameter int DATA_W  = 32,
   parameter int REG_AW  = 5,
   parameter int SHAMT_W = 5
) (
   input  logic           i_clk,
   input  logic           i_reset_n,
   exe_stage_fwd_if.slave bus
);
   localparam logic [5:0] OP_ADD  = 6'd0;
   localparam logic [5:0] OP_SUB  = 6'd1;
   localparam logic [5:0] OP_AND  = 6'd2;
   localparam logic [5:0] OP_OR   = 6'd3;
   localparam logic [5:0] OP_XOR  = 6'd4;
   localparam logic [5:0] OP_NOR  = 6'd5;
   localparam logic [5:0] OP_SLT  = 6'd6;
   localparam logic [5:0] OP_SLTU = 6'd7;
   localparam logic [5:0] OP_SLL  = 6'd8;
   localparam logic [5:0] OP_SRL  = 6'd9;
   localparam logic [5:0] OP_SRA  = 6'd10;
   localparam logic [5:0] OP_LUI  = 6'd11;
`ifdef EXE_MULT_EN
   localparam logic [5:0] OP_MULTU = 6'd12;
   localparam logic [5:0] OP_MFHI  = 6'd14;
   localparam logic [5:0] OP_MFLO  = 6'd15;
   localparam logic [SHAMT_W-1:0] LAST_ITER = SHAMT_W'(DATA_W - 1);
`endif

   logic [DATA_W-1:0] w_fwd_a;
   logic [DATA_W-1:0] w_fwd_b;
   logic [DATA_W-1:0] w_op_b;
   logic [DATA_W-1:0] w_alu;
   logic              w_stall;
   logic              w_busy;

   // Operand forwarding: MEM beats WB, register 0 is never forwarded
   always_comb begin
      w_fwd_a = bus.i_operand_a;
      if (bus.i_do_writeback_mem && bus.i_write_reg_mem != '0 &&
          bus.i_write_reg_mem == bus.i_read_reg_a)
         w_fwd_a = bus.i_data_mem;
      else if (bus.i_do_writeback_wb && bus.i_write_reg_wb != '0 &&
               bus.i_write_reg_wb == bus.i_read_reg_a)
         w_fwd_a = bus.i_data_wb;

      w_fwd_b = bus.i_operand_b;
      if (bus.i_do_writeback_mem && bus.i_write_reg_mem != '0 &&
          bus.i_write_reg_mem == bus.i_read_reg_b)
         w_fwd_b = bus.i_data_mem;
      else if (bus.i_do_writeback_wb && bus.i_write_reg_wb != '0 &&
               bus.i_write_reg_wb == bus.i_read_reg_b)
         w_fwd_b = bus.i_data_wb;
   end

   assign w_op_b = bus.i_alu_src ? bus.i_imm_ext : w_fwd_b;

`ifdef EXE_MULT_EN
   logic                r_mult_busy;
   logic [DATA_W-1:0]   r_hi;
   logic [DATA_W-1:0]   r_lo;
   logic [2*DATA_W-1:0] r_acc;
   logic [2*DATA_W-1:0] r_mcand;
   logic [DATA_W-1:0]   r_mplier;
   logic [SHAMT_W-1:0]  r_count;
   logic [2*DATA_W-1:0] w_mult_sum;
   logic                w_mult_accept;

   assign w_mult_sum    = r_acc + (r_mplier[0] ? r_mcand : '0);
   // MULTU starts only when it really enters EX/MEM (not held, not squashed)
   assign w_mult_accept = (bus.i_alu_control == OP_MULTU) && !bus.i_freeze && !bus.i_flush;
   assign w_busy        = r_mult_busy;
   assign w_stall       = r_mult_busy && (bus.i_alu_control == OP_MULTU ||
                                          bus.i_alu_control == OP_MFHI  ||
                                          bus.i_alu_control == OP_MFLO);

   // Multiplier: one partial product per cycle, HI/LO committed on the last iteration
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_mult_busy <= 1'b0;
         r_hi        <= '0;
         r_lo        <= '0;
         r_acc       <= '0;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_count     <= '0;
      end else if (r_mult_busy) begin
         r_acc    <= w_mult_sum;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_count  <= r_count + SHAMT_W'(1);
         if (r_count == LAST_ITER) begin
            {r_hi, r_lo} <= w_mult_sum;
            r_mult_busy  <= 1'b0;
         end
      end else if (w_mult_accept) begin
         r_mult_busy <= 1'b1;
         r_acc       <= '0;
         r_mcand     <= {{DATA_W{1'b0}}, w_fwd_a};
         r_mplier    <= w_fwd_b;
         r_count     <= '0;
      end
   end
`else
   assign w_busy  = 1'b0;
   assign w_stall = 1'b0;
`endif

   // ALU: result for the op currently in EX
   always_comb begin
      w_alu = '0;
      case (bus.i_alu_control)
         OP_ADD:  w_alu = w_fwd_a + w_op_b;
         OP_SUB:  w_alu = w_fwd_a - w_op_b;
         OP_AND:  w_alu = w_fwd_a & w_op_b;
         OP_OR:   w_alu = w_fwd_a | w_op_b;
         OP_XOR:  w_alu = w_fwd_a ^ w_op_b;
         OP_NOR:  w_alu = ~(w_fwd_a | w_op_b);
         OP_SLT:  w_alu = {{(DATA_W-1){1'b0}}, ($signed(w_fwd_a) < $signed(w_op_b))};
         OP_SLTU: w_alu = {{(DATA_W-1){1'b0}}, (w_fwd_a < w_op_b)};
         OP_SLL:  w_alu = w_op_b << bus.i_shamt;
         OP_SRL:  w_alu = w_op_b >> bus.i_shamt;
         OP_SRA:  w_alu = DATA_W'($signed(w_op_b) >>> bus.i_shamt);
         OP_LUI:  w_alu = w_op_b << (DATA_W / 2);
`ifdef EXE_MULT_EN
         OP_MFHI: w_alu = r_hi;
         OP_MFLO: w_alu = r_lo;
`endif
         default: w_alu = '0;
      endcase
   end

   // EX/MEM register: reset, then freeze hold, then bubble, then capture
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         bus.o_alu_result_pr   <= '0;
         bus.o_read_data_b_pr  <= '0;
         bus.o_write_reg_pr    <= '0;
         bus.o_do_writeback_pr <= 1'b0;
         bus.o_mem_read_pr     <= 1'b0;
         bus.o_mem_write_pr    <= 1'b0;
         bus.o_mem_to_reg_pr   <= 1'b0;
         bus.o_alu_control_pr  <= '0;
         bus.o_instr_pr        <= '0;
      end else if (bus.i_freeze) begin
         // hold
      end else if (bus.i_flush || w_stall) begin
         bus.o_alu_result_pr   <= '0;
         bus.o_read_data_b_pr  <= '0;
         bus.o_write_reg_pr    <= '0;
         bus.o_do_writeback_pr <= 1'b0;
         bus.o_mem_read_pr     <= 1'b0;
         bus.o_mem_write_pr    <= 1'b0;
         bus.o_mem_to_reg_pr   <= 1'b0;
         bus.o_alu_control_pr  <= '0;
         bus.o_instr_pr        <= '0;
      end else begin
         bus.o_alu_result_pr   <= w_alu;
         bus.o_read_data_b_pr  <= w_fwd_b;
         bus.o_write_reg_pr    <= bus.i_write_reg;
         bus.o_do_writeback_pr <= bus.i_do_writeback_id;
         bus.o_mem_read_pr     <= bus.i_mem_read;
         bus.o_mem_write_pr    <= bus.i_mem_write;
         bus.o_mem_to_reg_pr   <= bus.i_mem_to_reg;
         bus.o_alu_control_pr  <= bus.i_alu_control;
         bus.o_instr_pr        <= bus.i_instr;
      end
   end

   assign bus.o_alu_result = w_alu;
   assign bus.o_stall      = w_stall;
   assign bus.o_mult_busy  = w_busy;
endmodule
